sram_port_arbiter: RTL

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

---
 rtl/sram_port_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/sram_port_arbiter.sv
// Two-requester arbiter in front of a single-port SRAM macro sharing clk.
// Optional SRAM_ARB_RR_EN: round-robin tie-break instead of fixed A-priority.
module sram_port_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_a,
    input  logic       req_b,
    input  logic       we_a,
    input  logic       we_b,
    input  logic [9:0] addr_a,
    input  logic [9:0] addr_b,
    input  logic [7:0] wdata_a,
    input  logic [7:0] wdata_b,
    output logic       gnt_a,
    output logic       gnt_b,
    output logic       rvalid_a,
    output logic       rvalid_b,
    output logic [7:0] rdata_a,
    output logic [7:0] rdata_b,
    output logic       csb0,
    output logic       web0,
    output logic       wmask0,
    output logic [9:0] addr0,
    output logic [7:0] din0,
    input  logic [7:0] dout0
);

    typedef enum logic {IDLE, CMD} state_t;

    state_t     state_reg, state_next;
    logic       own_b_reg, own_b_next;
    logic       web0_reg, web0_next;
    logic [9:0] addr0_reg, addr0_next;
    logic [7:0] din0_reg, din0_next;

    logic       req_a_eff, req_b_eff;
    logic       pick_a, pick_b;

    logic       rd_s1_vld_reg;
    logic       rd_s1_own_reg;
    logic [1:0] rd_hit;

    // The grantee of the current command still holds req this edge; ignore it.
    assign req_a_eff = req_a & ~((state_reg == CMD) & ~own_b_reg);
    assign req_b_eff = req_b & ~((state_reg == CMD) &  own_b_reg);

`ifdef SRAM_ARB_RR_EN
    logic rr_ptr_reg, rr_ptr_next;

    // rr_ptr_reg = 0 points at A, 1 points at B.
    assign pick_a = req_a_eff & (~req_b_eff | ~rr_ptr_reg);
    assign pick_b = req_b_eff & ~pick_a;

    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (pick_a) begin
            rr_ptr_next = 1'b1;
        end else if (pick_b) begin
            rr_ptr_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_reg <= 1'b0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
        end
    end
`else
    assign pick_a = req_a_eff;
    assign pick_b = req_b_eff & ~req_a_eff;
`endif

    // State register plus the command fields launched with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            own_b_reg <= 1'b0;
            web0_reg  <= 1'b1;
            addr0_reg <= '0;
            din0_reg  <= '0;
        end else begin
            state_reg <= state_next;
            own_b_reg <= own_b_next;
            web0_reg  <= web0_next;
            addr0_reg <= addr0_next;
            din0_reg  <= din0_next;
        end
    end

    // Next-state logic: any surviving request issues a command next cycle.
    always_comb begin
        state_next = IDLE;
        if (pick_a || pick_b) begin
            state_next = CMD;
        end
    end

    // Command field selection for the winner; fields hold while idle.
    always_comb begin
        own_b_next = own_b_reg;
        web0_next  = 1'b1;
        addr0_next = addr0_reg;
        din0_next  = din0_reg;
        if (pick_a) begin
            own_b_next = 1'b0;
            web0_next  = ~we_a;
            addr0_next = addr_a;
            din0_next  = wdata_a;
        end else if (pick_b) begin
            own_b_next = 1'b1;
            web0_next  = ~we_b;
            addr0_next = addr_b;
            din0_next  = wdata_b;
        end
    end

    // Moore outputs; csb0 follows the state so reset releases the SRAM at once.
    always_comb begin
        csb0  = 1'b1;
        web0  = 1'b1;
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (state_reg == CMD) begin
            csb0  = 1'b0;
            web0  = web0_reg;
            gnt_a = ~own_b_reg;
            gnt_b =  own_b_reg;
        end
    end

    assign addr0  = addr0_reg;
    assign din0   = din0_reg;
    assign wmask0 = 1'b1;

    // Stage 1 of the owner pipeline: which requester's read is in the macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_s1_vld_reg <= 1'b0;
            rd_s1_own_reg <= 1'b0;
        end else begin
            rd_s1_vld_reg <= (state_reg == CMD) & web0_reg;
            rd_s1_own_reg <= own_b_reg;
        end
    end

    assign rd_hit = {rd_s1_vld_reg & rd_s1_own_reg, rd_s1_vld_reg & ~rd_s1_own_reg};

    // Stage 2: per-requester capture of dout0 and the rvalid pulse.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic       rvalid_reg;
            logic [7:0] rdata_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rvalid_reg <= 1'b0;
                    rdata_reg  <= '0;
                end else begin
                    rvalid_reg <= rd_hit[gi];
                    if (rd_hit[gi]) begin
                        rdata_reg <= dout0;
                    end
                end
            end
        end
    endgenerate

    assign rvalid_a = g_rd[0].rvalid_reg;
    assign rvalid_b = g_rd[1].rvalid_reg;
    assign rdata_a  = g_rd[0].rdata_reg;
    assign rdata_b  = g_rd[1].rdata_reg;

endmodule
